// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// the register-file record with its reset value, and a byte-lane merge helper.
package clint_pkg;

    localparam logic [15:0] clint_msip      = 16'h0000;
    localparam logic [15:0] clint_mtimecmp  = 16'h4000;
    localparam logic [15:0] clint_mtimecmph = 16'h4004;
    localparam logic [15:0] clint_mtime     = 16'hBFF8;
    localparam logic [15:0] clint_mtimeh    = 16'hBFFC;

    typedef struct packed {
        logic [63:0] mtime;
        logic [63:0] mtimecmp;
        logic        msip;
        logic        ready;
        logic [31:0] rdata;
        logic        timer_irpt;
        logic        soft_irpt;
    } clint_reg_type;

    localparam clint_reg_type init_clint_reg = '{
        mtime:      64'h0,
        mtimecmp:   64'hFFFF_FFFF_FFFF_FFFF,
        msip:       1'b0,
        ready:      1'b0,
        rdata:      32'h0,
        timer_irpt: 1'b0,
        soft_irpt:  1'b0
    };

    // Replace only the byte lanes enabled in strb.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime driven by a clock prescaler, 64-bit
// mtimecmp compare for the machine timer interrupt, and a one-bit msip.
module clint
    import clint_pkg::*;
#(
    parameter int clock_rate = 100000000,
    parameter int rtc_rate   = 1000000
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        clint_valid,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        timer_irpt,
    output logic        soft_irpt
);

    localparam int DIV = clock_rate / rtc_rate;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    clint_reg_type r_q, r_d;
    logic [PW-1:0] presc_q, presc_d;

    logic        tick;
    logic        req_wr;
    logic [15:0] off;
    logic [31:0] rd_data;
    logic        unused_addr;

    assign off         = clint_addr[15:0];
    assign req_wr      = clint_valid && (clint_wstrb != 4'h0);
    assign unused_addr = ^clint_addr[31:16];

    always_comb begin
        tick    = (presc_q == PMAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        rd_data = '0;
        case (off)
            clint_msip:      rd_data = {31'b0, r_q.msip};
            clint_mtimecmp:  rd_data = r_q.mtimecmp[31:0];
            clint_mtimecmph: rd_data = r_q.mtimecmp[63:32];
            clint_mtime:     rd_data = r_q.mtime[31:0];
            clint_mtimeh:    rd_data = r_q.mtime[63:32];
            default:         rd_data = '0;
        endcase
    end

    // Write data is merged into the pre-tick mtime, so a bus write to either
    // word freezes the whole counter for that cycle.
    always_comb begin
        r_d            = r_q;
        r_d.ready      = clint_valid;
        r_d.rdata      = (clint_valid && !req_wr) ? rd_data : '0;
        r_d.timer_irpt = (r_q.mtime >= r_q.mtimecmp);
        r_d.soft_irpt  = r_q.msip;
        if (tick) r_d.mtime = r_q.mtime + 64'd1;
        if (req_wr) begin
            case (off)
                clint_msip:
                    if (clint_wstrb[0]) r_d.msip = clint_wdata[0];
                clint_mtimecmp:
                    r_d.mtimecmp[31:0] = merge_bytes(r_q.mtimecmp[31:0], clint_wdata, clint_wstrb);
                clint_mtimecmph:
                    r_d.mtimecmp[63:32] = merge_bytes(r_q.mtimecmp[63:32], clint_wdata, clint_wstrb);
                clint_mtime:
                    r_d.mtime = {r_q.mtime[63:32],
                                 merge_bytes(r_q.mtime[31:0], clint_wdata, clint_wstrb)};
                clint_mtimeh:
                    r_d.mtime = {merge_bytes(r_q.mtime[63:32], clint_wdata, clint_wstrb),
                                 r_q.mtime[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q     <= init_clint_reg;
            presc_q <= '0;
        end else begin
            r_q     <= r_d;
            presc_q <= presc_d;
        end
    end

    assign clint_rdata = r_q.rdata;
    assign clint_ready = r_q.ready;
    assign timer_irpt  = r_q.timer_irpt;
    assign soft_irpt   = r_q.soft_irpt;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint with a divider of 4, random traffic checked
// against a cycle-level behavioural model of the register map.
module tb_clint;

    localparam int CLK_RATE = 4;
    localparam int RTC_RATE = 1;
    localparam int DIV      = CLK_RATE / RTC_RATE;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clint_valid = 1'b0;
    logic [31:0] clint_addr  = '0;
    logic [31:0] clint_wdata = '0;
    logic [3:0]  clint_wstrb = '0;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        timer_irpt;
    logic        soft_irpt;

    int errors = 0;
    int checks = 0;

    clint #(.clock_rate(CLK_RATE), .rtc_rate(RTC_RATE)) dut (
        .rst(rst), .clk(clk), .clint_valid(clint_valid), .clint_addr(clint_addr),
        .clint_wdata(clint_wdata), .clint_wstrb(clint_wstrb), .clint_rdata(clint_rdata),
        .clint_ready(clint_ready), .timer_irpt(timer_irpt), .soft_irpt(soft_irpt)
    );

    always #5 clk = ~clk;

    // Reference model: architectural registers as plain 64-bit numbers,
    // ticks derived from the count of clock edges since reset release.
    longint unsigned m_mtime  = 0;
    longint unsigned m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    longint unsigned m_cycles = 0;
    bit              m_msip   = 0;
    logic            e_ready  = 0;
    logic            e_timer  = 0;
    logic            e_soft   = 0;
    logic [31:0]     e_rdata  = 0;

    function automatic logic [31:0] mread(input logic [15:0] a);
        case (a)
            16'h0000: return {31'b0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_mtime[31:0];
            16'hBFFC: return m_mtime[63:32];
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] w,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        bit wrote_time;
        if (!rst) begin
            m_mtime = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 0; m_cycles = 0;
            e_ready = 0; e_rdata = 0; e_timer = 0; e_soft = 0;
        end else begin
            e_timer = (m_mtime >= m_cmp);
            e_soft  = m_msip;
            e_ready = clint_valid;
            e_rdata = (clint_valid && clint_wstrb == 4'h0) ? mread(clint_addr[15:0]) : 32'h0;
            wrote_time = 0;
            if (clint_valid && clint_wstrb != 4'h0) begin
                case (clint_addr[15:0])
                    16'h0000: if (clint_wstrb[0]) m_msip = clint_wdata[0];
                    16'h4000: m_cmp[31:0]    = mmerge(m_cmp[31:0], clint_wdata, clint_wstrb);
                    16'h4004: m_cmp[63:32]   = mmerge(m_cmp[63:32], clint_wdata, clint_wstrb);
                    16'hBFF8: begin m_mtime[31:0]  = mmerge(m_mtime[31:0], clint_wdata, clint_wstrb);  wrote_time = 1; end
                    16'hBFFC: begin m_mtime[63:32] = mmerge(m_mtime[63:32], clint_wdata, clint_wstrb); wrote_time = 1; end
                    default: ;
                endcase
            end
            if (!wrote_time && (m_cycles % DIV) == DIV - 1) m_mtime = m_mtime + 1;
            m_cycles = m_cycles + 1;
        end
    end

    // Apply one cycle of inputs; return just after the following falling edge.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] s);
        clint_valid = v; clint_addr = a; clint_wdata = w; clint_wstrb = s;
        @(negedge clk);
        clint_valid = 0; clint_wstrb = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    // Idle until the next clock edge is the given prescaler phase (bounded).
    task automatic wait_phase(input int ph);
        for (int i = 0; i < DIV + 1 && int'(m_cycles % DIV) != ph; i++) idle(1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(3);
        checks++; if (clint_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", clint_ready); end
        checks++; if (clint_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", clint_rdata); end
        checks++; if (timer_irpt !== 1'b0) begin errors++; $display("FAIL reset_timer got=%b exp=0", timer_irpt); end
        checks++; if (soft_irpt !== 1'b0) begin errors++; $display("FAIL reset_soft got=%b exp=0", soft_irpt); end
        rst = 1'b1;
        drive(1'b1, 32'h4004, 32'h0, 4'h0);
        checks++; if (clint_ready !== 1'b1) begin errors++; $display("FAIL reset_cmph_ready got=%b exp=1", clint_ready); end
        checks++; if (clint_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmph_rdata got=%h exp=ffffffff", clint_rdata); end
        checks++; if (timer_irpt !== 1'b0) begin errors++; $display("FAIL reset_cmph_timer got=%b exp=0", timer_irpt); end
        // request presented in the same cycle reset asserts is dropped
        rst = 1'b0;
        drive(1'b1, 32'h4004, 32'h0, 4'h0);
        checks++; if (clint_ready !== 1'b0) begin errors++; $display("FAIL reset_drop_same got=%b exp=0", clint_ready); end
        rst = 1'b1;
        drive(1'b1, 32'h4000, 32'h0, 4'h0);
        rst = 1'b0;
        idle(1);
        checks++; if (clint_ready !== 1'b0 || clint_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_drop_mid ready=%b rdata=%h exp ready=0 rdata=0", clint_ready, clint_rdata); end
        rst = 1'b1;
    endtask

    task automatic test_tick_rate();
        do_reset();
        idle(40);
        drive(1'b1, 32'hBFF8, 32'h0, 4'h0);
        checks++; if (clint_rdata !== 32'd10) begin errors++; $display("FAIL tick_rate got=%0d exp=10", clint_rdata); end
        checks++; if (clint_rdata !== e_rdata) begin errors++; $display("FAIL tick_rate_model got=%h exp=%h", clint_rdata, e_rdata); end
    endtask

    task automatic test_carry();
        do_reset();
        drive(1'b1, 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        drive(1'b1, 32'hBFFC, 32'h0, 4'hF);
        wait_phase(DIV - 1);
        idle(1);
        drive(1'b1, 32'hBFFC, 32'h0, 4'h0);
        checks++; if (clint_rdata !== 32'd1) begin errors++; $display("FAIL carry_hi got=%h exp=1", clint_rdata); end
        drive(1'b1, 32'hBFF8, 32'h0, 4'h0);
        checks++; if (clint_rdata !== 32'd0) begin errors++; $display("FAIL carry_lo got=%h exp=0", clint_rdata); end
        // 2^64-1 wraps to 0
        drive(1'b1, 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        drive(1'b1, 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wait_phase(DIV - 1);
        idle(1);
        drive(1'b1, 32'hBFFC, 32'h0, 4'h0);
        checks++; if (clint_rdata !== 32'd0) begin errors++; $display("FAIL wrap_hi got=%h exp=0", clint_rdata); end
        drive(1'b1, 32'hBFF8, 32'h0, 4'h0);
        checks++; if (clint_rdata !== 32'd0) begin errors++; $display("FAIL wrap_lo got=%h exp=0", clint_rdata); end
    endtask

    task automatic test_irq();
        longint unsigned prev;
        bit rose = 0;
        do_reset();
        drive(1'b1, 32'h4000, 32'd20, 4'hF);
        drive(1'b1, 32'h4004, 32'd0, 4'hF);
        for (int i = 0; i < 200 && !(rose && m_mtime >= 22); i++) begin
            prev = m_mtime;
            idle(1);
            checks++; if (timer_irpt !== (prev >= 20)) begin
                errors++; $display("FAIL irq_level mtime_prev=%0d got=%b exp=%b", prev, timer_irpt, prev >= 20); end
            if (timer_irpt === 1'b1) rose = 1;
        end
        checks++; if (!rose) begin errors++; $display("FAIL irq_rise got=0 exp=1"); end
        drive(1'b1, 32'h4004, 32'hFFFF_FFFF, 4'hF);
        checks++; if (timer_irpt !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b exp=1", timer_irpt); end
        drive(1'b1, 32'h4000, 32'hFFFF_FFFF, 4'hF);
        checks++; if (timer_irpt !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b exp=0", timer_irpt); end
    endtask

    task automatic test_strobe();
        do_reset();
        drive(1'b1, 32'h4000, 32'hAABB_CCDD, 4'h2);
        drive(1'b1, 32'h4000, 32'h0, 4'h0);
        checks++; if (clint_rdata !== 32'hFFFF_CCFF) begin errors++; $display("FAIL strobe got=%h exp=ffffccff", clint_rdata); end
    endtask

    task automatic test_msip();
        do_reset();
        drive(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF);
        checks++; if (soft_irpt !== 1'b0) begin errors++; $display("FAIL msip_lag got=%b exp=0", soft_irpt); end
        drive(1'b1, 32'h0, 32'h0, 4'h0);
        checks++; if (clint_rdata !== 32'h1) begin errors++; $display("FAIL msip_read got=%h exp=1", clint_rdata); end
        checks++; if (soft_irpt !== 1'b1) begin errors++; $display("FAIL msip_soft got=%b exp=1", soft_irpt); end
        drive(1'b1, 32'h0, 32'h0, 4'h2);
        drive(1'b1, 32'h0, 32'h0, 4'h0);
        checks++; if (clint_rdata !== 32'h1) begin errors++; $display("FAIL msip_lane got=%h exp=1", clint_rdata); end
        drive(1'b1, 32'h0, 32'h0, 4'h1);
        idle(1);
        checks++; if (soft_irpt !== 1'b0) begin errors++; $display("FAIL msip_clear got=%b exp=0", soft_irpt); end
    endtask

    task automatic test_collision();
        do_reset();
        wait_phase(DIV - 1);
        drive(1'b1, 32'hBFF8, 32'h1234_5678, 4'hF);
        drive(1'b1, 32'hBFF8, 32'h0, 4'h0);
        checks++; if (clint_rdata !== 32'h1234_5678) begin errors++; $display("FAIL collide_lo got=%h exp=12345678", clint_rdata); end
        wait_phase(DIV - 1);
        drive(1'b1, 32'hBFFC, 32'hCAFE_0001, 4'hF);
        drive(1'b1, 32'hBFFC, 32'h0, 4'h0);
        checks++; if (clint_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL collide_hi got=%h exp=cafe0001", clint_rdata); end
        drive(1'b1, 32'hBFF8, 32'h0, 4'h0);
        checks++; if (clint_rdata !== e_rdata) begin errors++; $display("FAIL collide_lo_model got=%h exp=%h", clint_rdata, e_rdata); end
        drive(1'b1, 32'h1234, 32'h0, 4'h0);
        checks++; if (clint_ready !== 1'b1 || clint_rdata !== 32'h0) begin
            errors++; $display("FAIL unmapped_read ready=%b rdata=%h exp ready=1 rdata=0", clint_ready, clint_rdata); end
        idle(1);
        checks++; if (clint_ready !== 1'b0 || clint_rdata !== 32'h0) begin
            errors++; $display("FAIL ready_pulse ready=%b rdata=%h exp ready=0 rdata=0", clint_ready, clint_rdata); end
    endtask

    task automatic test_random();
        logic [31:0] addrs [8];
        logic [31:0] a, w;
        logic [3:0]  s;
        logic        v;
        addrs[0] = 32'h0000; addrs[1] = 32'h4000; addrs[2] = 32'h4004; addrs[3] = 32'hBFF8;
        addrs[4] = 32'hBFFC; addrs[5] = 32'h1234; addrs[6] = 32'h0004; addrs[7] = 32'h0001_4000;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom % 3) != 0;
            a = addrs[$urandom % 8];
            s = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
            if (a == 32'h4004 || a == 32'hBFFC)      w = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : 32'h0;
            else if (a == 32'h4000 || a == 32'hBFF8) w = 32'($urandom_range(0, 300));
            else                                     w = $urandom;
            drive(v, a, w, s);
            checks++; if (clint_ready !== e_ready) begin errors++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, clint_ready, e_ready); end
            checks++; if (clint_rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, clint_rdata, e_rdata); end
            checks++; if (timer_irpt !== e_timer) begin errors++; $display("FAIL rnd_timer i=%0d got=%b exp=%b", i, timer_irpt, e_timer); end
            checks++; if (soft_irpt !== e_soft) begin errors++; $display("FAIL rnd_soft i=%0d got=%b exp=%b", i, soft_irpt, e_soft); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_tick_rate();
        test_carry();
        test_irq();
        test_strobe();
        test_msip();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL take parameter clock_rate, default 100000000, core clock frequency in Hz.
REQ-002 SHALL take parameter rtc_rate, default 1000000, mtime tick frequency in Hz; clock_rate/rtc_rate SHALL be an integer >= 1.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-005 SHALL have port clint_valid  input  1  bus request strobe; each cycle high is one request.
REQ-006 SHALL have port clint_addr  input  32  byte address; only bits [15:0] decoded.
REQ-007 SHALL have port clint_wdata  input  32  write data.
REQ-008 SHALL have port clint_wstrb  input  4  byte write enables; 0 means read.
REQ-009 SHALL have port clint_rdata  output  32  read data, valid while clint_ready=1.
REQ-010 SHALL have port clint_ready  output  1  one-cycle response pulse.
REQ-011 SHALL have port timer_irpt  output  1  machine timer interrupt, to the CSR unit.
REQ-012 SHALL have port soft_irpt  output  1  machine software interrupt (msip bit 0).

Function
REQ-013 SHALL map offsets: 0x0000 msip, 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32], 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32].
REQ-014 SHALL register each request; clint_ready=1 exactly one cycle after the clint_valid cycle, 0 otherwise; back-to-back requests give back-to-back ready.
REQ-015 SHALL return rdata sampled from register values of the request cycle; rdata=0 when clint_ready=0.
REQ-016 SHALL apply writes per byte lane under clint_wstrb, effective the cycle after the request.
REQ-017 SHALL implement msip as 1 writable bit (bit 0); other bits read 0, writes ignored.
REQ-018 SHALL treat unmapped offsets as read 0 / write ignored, still asserting clint_ready.
REQ-019 SHALL have a prescaler counter 0..(clock_rate/rtc_rate-1); tick when it equals max, then wrap to 0; divider 1 means tick every cycle.
REQ-020 SHALL increment mtime by 1 on each tick as a single 64-bit add (carry from low into high word), wrapping 2^64-1 -> 0.
REQ-021 SHALL let a bus write to an mtime word take precedence over a tick in the same cycle (written value stored, no increment that cycle); other word still increments if tick applies to unwritten bytes -- no: whole mtime holds on write cycle.
REQ-022 SHALL register timer_irpt <= (mtime >= mtimecmp), unsigned 64-bit compare, so it follows register changes by one cycle and is level, not sticky.
REQ-023 SHALL register soft_irpt <= msip[0].

Reset
REQ-024 SHALL on rst=0 set mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, clint_ready=0, clint_rdata=0, timer_irpt=0, soft_irpt=0.
REQ-025 SHALL drop any request in flight when reset asserts mid-access (no ready after reset).

Structure
REQ-026 SHALL place the offset constants (clint_msip, clint_mtimecmp, clint_mtimecmph, clint_mtime, clint_mtimeh) in constants and a clint_reg_type struct with its init_clint_reg value in wires.
REQ-027 SHALL be one module with no sub-modules; instantiated beside csr with timer_irpt wired to csr.timer_irpt.

Verification
REQ-028 SHALL check reset: after rst release, read 0x4004 -> rdata 0xFFFFFFFF one cycle later, timer_irpt=0.
REQ-029 SHALL check tick rate: clock_rate=4, rtc_rate=1, 40 cycles after reset -> mtime low reads 10.
REQ-030 SHALL check carry: write mtime=0x0000_0000_FFFF_FFFF, divider 1, next tick -> mtimeh reads 1, mtime low reads 0.
REQ-031 SHALL check interrupt: mtimecmp=20, mtime counts from 0 -> timer_irpt rises one cycle after mtime=20; rewrite mtimecmp=0xFFFFFFFF_FFFFFFFF -> falls one cycle after write completes.
REQ-032 SHALL check byte strobes: write 0xAABBCCDD to 0x4000 with wstrb=0x2 after reset -> reads 0xFFFFCCFF.
REQ-033 SHALL check collision and unmapped: mtime write coincident with tick stores written value exactly; read 0x1234 -> rdata 0, ready 1 cycle later.

Correction to REQ-021: the whole 64-bit mtime SHALL hold its written value (unwritten bytes unchanged, no increment) in the cycle a bus write to either mtime word lands.
